// File: rtl/factorial_seq.sv
// factorial_seq: sequential n! engine, one multiply per clock.
//
// A controller pulses start with the operand on n_in while busy is low. The
// engine multiplies acc by i = 2, 3, ..., n one step per cycle. It then pulses
// done for one cycle and latches result/overflow, which hold until the next done.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request, sampled only while busy == 0
//   n_in      operand n, captured on an accepted start
//   busy      high while a computation is in flight
//   done      one-cycle pulse, result/overflow valid from this cycle
//   result    n! modulo 2**RES_W
//   overflow  n! did not fit in RES_W bits
module factorial_seq #(
    parameter int unsigned N_W   = 4,
    parameter int unsigned RES_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_W-1:0]   n_in,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] result,
    output logic             overflow
);

    typedef enum logic [0:0] {StIdle, StCalc} state_t;

    localparam logic [RES_W-1:0] AccInit = RES_W'(1);
    localparam logic [N_W:0]     IInit   = (N_W + 1)'(2);

    state_t             state_q, state_d;
    logic [RES_W-1:0]   acc_q, acc_d;
    // One bit wider than n so that i = 2**N_W ends the loop instead of wrapping.
    logic [N_W:0]       i_q, i_d;
    logic [N_W-1:0]     n_q, n_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               overflow_q, overflow_d;

    // The multiplier is only used while i <= n_q < 2**N_W, so i fits in N_W bits.
    // Zero-extended operands keep the full product in RES_W+N_W bits.
    logic [RES_W+N_W-1:0] prod;
    assign prod = {{N_W{1'b0}}, acc_q} * {{RES_W{1'b0}}, i_q[N_W-1:0]};

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        i_d        = i_q;
        n_d        = n_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        overflow_d = overflow_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    n_d     = n_in;
                    acc_d   = AccInit;
                    i_d     = IInit;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (i_q <= {1'b0, n_q}) begin
                    acc_d = prod[RES_W-1:0];
                    // Sticky: once set, acc keeps accumulating truncated products.
                    ovf_d = ovf_q | (|prod[RES_W+N_W-1:RES_W]);
                    i_d   = i_q + 1'b1;
                end else begin
                    result_d   = acc_q;
                    overflow_d = ovf_q;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            acc_q      <= AccInit;
            i_q        <= IInit;
            n_q        <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            i_q        <= i_d;
            n_q        <= n_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_factorial_seq.sv
// Testbench for factorial_seq: directed literal checks plus randomized traffic,
// with every cycle compared against a transaction-level factorial model.
module tb_factorial_seq;

    localparam int unsigned N_W   = 4;
    localparam int unsigned RES_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [N_W-1:0]   n_in = '0;
    logic             busy;
    logic             done;
    logic [RES_W-1:0] result;
    logic             overflow;

    int total = 0;
    int bad = 0;

    factorial_seq #(.N_W(N_W), .RES_W(RES_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .n_in     (n_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Exact n! in 64 bits (15! < 2**41).
    function automatic logic [63:0] fact(input int n);
        logic [63:0] f = 64'd1;
        for (int k = 2; k <= n; k++) f = f * 64'(k);
        return f;
    endfunction

    // Reference: an accepted op takes max(n,1) cycles, then reports n! mod 2**32
    // and whether n! >= 2**32.
    logic             m_busy, m_done, m_ovf;
    logic [RES_W-1:0] m_res;
    logic [N_W-1:0]   m_n;
    int               m_left;
    logic [63:0]      m_full;
    assign m_full = fact(int'(m_n));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_res  <= '0;
            m_ovf  <= 1'b0;
            m_n    <= '0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy <= 1'b1;
                    m_n    <= n_in;
                    m_left <= (n_in < 2) ? 1 : int'(n_in);
                end
            end else if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_res  <= m_full[RES_W-1:0];
                m_ovf  <= |m_full[63:RES_W];
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("result", result, m_res);
        check("overflow", overflow, m_ovf);
    end

    // Starts an op from #1 after an edge; returns #1 after the done edge.
    // With poke set, a start with n_in=2 is pulsed while the op is busy.
    task automatic do_op(input int n, input logic [63:0] exp_res, input logic exp_ovf,
                         input bit poke);
        int  cyc = 0;
        bit  seen = 1'b0;
        start = 1'b1;
        n_in  = n[N_W-1:0];
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            if (poke && k == 2) begin
                start = 1'b1;
                n_in  = 4'd2;
            end else if (poke && k == 3) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                cyc  = k;
            end
        end
        check("lit_latency", 64'(cyc), 64'((n < 2) ? 1 : n));
        check("lit_result", result, exp_res);
        check("lit_overflow", overflow, exp_ovf);
    endtask

    initial begin
        bit saw_done;

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 0);
        check("rst_overflow", overflow, 1'b0);
        @(posedge clk);
        #1;

        do_op(0, 1, 1'b0, 1'b0);
        do_op(1, 1, 1'b0, 1'b0);
        do_op(5, 120, 1'b0, 1'b0);
        do_op(12, 479001600, 1'b0, 1'b0);
        do_op(13, 1932053504, 1'b1, 1'b0);
        do_op(3, 6, 1'b0, 1'b0);
        do_op(7, 5040, 1'b0, 1'b1);

        // Abort an n=9 op with reset: outputs clear, no done follows.
        start = 1'b1;
        n_in  = 4'd9;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_result", result, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1 if (done) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 1'b0);
        do_op(4, 24, 1'b0, 1'b0);

        // Mid-cycle reset clears outputs without any clock edge.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_busy", busy, 1'b0);
        check("async_done", done, 1'b0);
        check("async_result", result, 0);
        check("async_overflow", overflow, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #2;
            start = ($urandom_range(2, 0) == 0);
            n_in  = N_W'($urandom);
            if ($urandom_range(499, 0) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
